// File: rtl/mux_sel_sequencer.sv
// ---------------------------------------------------------------------------
// mux_sel_sequencer
//   Context sequencer feeding the 4-bit select of a PE input mux16x1.
//   A small table of select values is loaded over the config bus while IDLE.
//   On start, entries 0..len are stepped through one per cycle. This is
//   repeated for iters+1 passes. Then done pulses and the block returns to IDLE.
//
// Optional feature (macro MUX_SEQ_OUT_REG_EN):
//   When defined, s and ctx_idx are registered, which adds one cycle of
//   latency. done is delayed by the same cycle so it stays aligned with the
//   last select.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous reset, active-high
//   i_cfg_we     table write strobe (IDLE only; raises o_cfg_err in RUN)
//   i_cfg_addr   table write address
//   i_cfg_data   table write data
//   i_cfg_len    last active entry index, latched at start
//   i_cfg_iters  number of passes minus 1, latched at start
//   i_start      begin a sequence (ignored outside IDLE)
//   i_stall      freeze the sequencer for this cycle
//   o_s          select value driven to the mux
//   o_ctx_idx    current table pointer
//   o_running    high while in RUN
//   o_done       one-cycle pulse after the final entry of the final pass
//   o_cfg_err    one-cycle pulse after a write attempt outside IDLE
// ---------------------------------------------------------------------------
module mux_sel_sequencer #(
    parameter int SEL_W  = 4,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int ITER_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_we,
    input  logic [PTR_W-1:0]  i_cfg_addr,
    input  logic [SEL_W-1:0]  i_cfg_data,
    input  logic [PTR_W-1:0]  i_cfg_len,
    input  logic [ITER_W-1:0] i_cfg_iters,
    input  logic              i_start,
    input  logic              i_stall,
    output logic [SEL_W-1:0]  o_s,
    output logic [PTR_W-1:0]  o_ctx_idx,
    output logic              o_running,
    output logic              o_done,
    output logic              o_cfg_err
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t              r_state, w_state_nxt;
    logic [SEL_W-1:0]    r_table [DEPTH];
    logic [PTR_W-1:0]    r_ptr, w_ptr_nxt;
    logic [ITER_W-1:0]   r_pass_cnt, w_pass_nxt;
    logic [PTR_W-1:0]    r_len_q;
    logic [ITER_W-1:0]   r_iters_q;
    logic                r_done, w_done_nxt;
    logic                r_cfg_err, w_cfg_err_nxt;
    logic                w_tbl_we;
    logic                w_latch;
    logic [SEL_W-1:0]    w_sel;
    logic [PTR_W-1:0]    w_idx;

    // Next-state / control
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_pass_nxt    = r_pass_cnt;
        w_done_nxt    = 1'b0;
        w_tbl_we      = 1'b0;
        w_latch       = 1'b0;
        w_cfg_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A write that coincides with start still lands in the table.
                w_tbl_we = i_cfg_we;
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                    w_ptr_nxt   = '0;
                    w_pass_nxt  = '0;
                    w_latch     = 1'b1;
                end
            end
            ST_RUN: begin
                w_cfg_err_nxt = i_cfg_we;
                // Stall has priority, even over the terminal condition.
                if (!i_stall) begin
                    if (r_ptr != r_len_q) begin
                        w_ptr_nxt = PTR_W'(r_ptr + 1'b1);
                    end else if (r_pass_cnt < r_iters_q) begin
                        w_ptr_nxt  = '0;
                        w_pass_nxt = ITER_W'(r_pass_cnt + 1'b1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_pass_cnt <= '0;
            r_len_q    <= '0;
            r_iters_q  <= '0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_pass_cnt <= w_pass_nxt;
            r_done     <= w_done_nxt;
            r_cfg_err  <= w_cfg_err_nxt;
            if (w_latch) begin
                r_len_q   <= i_cfg_len;
                r_iters_q <= i_cfg_iters;
            end
        end
    end

    // Context table, cleared by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
        end else if (w_tbl_we) begin
            r_table[i_cfg_addr] <= i_cfg_data;
        end
    end

    // Select and pointer are forced to 0 outside RUN
    assign w_sel = (r_state == ST_RUN) ? r_table[r_ptr] : '0;
    assign w_idx = (r_state == ST_RUN) ? r_ptr : '0;

    assign o_running = (r_state == ST_RUN);
    assign o_cfg_err = r_cfg_err;

`ifdef MUX_SEQ_OUT_REG_EN
    logic [SEL_W-1:0] r_s_q;
    logic [PTR_W-1:0] r_idx_q;
    logic             r_done_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s_q    <= '0;
            r_idx_q  <= '0;
            r_done_d <= 1'b0;
        end else begin
            r_s_q    <= w_sel;
            r_idx_q  <= w_idx;
            r_done_d <= r_done;
        end
    end

    assign o_s       = r_s_q;
    assign o_ctx_idx = r_idx_q;
    assign o_done    = r_done_d;
`else
    assign o_s       = w_sel;
    assign o_ctx_idx = w_idx;
    assign o_done    = r_done;
`endif

endmodule

// File: tb/tb_mux_sel_sequencer.sv
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst, cfg_we, start, stall;
    logic [2:0] cfg_addr, cfg_len, ctx_idx;
    logic [3:0] cfg_data, s;
    logic [7:0] cfg_iters;
    logic       running, done, cfg_err;

    always #5 clk = ~clk;

    mux_sel_sequencer dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cfg_we   (cfg_we),
        .i_cfg_addr (cfg_addr),
        .i_cfg_data (cfg_data),
        .i_cfg_len  (cfg_len),
        .i_cfg_iters(cfg_iters),
        .i_start    (start),
        .i_stall    (stall),
        .o_s        (s),
        .o_ctx_idx  (ctx_idx),
        .o_running  (running),
        .o_done     (done),
        .o_cfg_err  (cfg_err)
    );

    typedef struct {
        logic       rst, we;
        logic [2:0] addr;
        logic [3:0] data;
        logic [2:0] len;
        logic [7:0] iters;
        logic       start, stall;
        logic [3:0] es;
        logic [2:0] ei;
        logic       er, ed, ee;
    } vec_t;

    typedef struct {
        logic [3:0] es;
        logic [2:0] ei;
        logic       er, ed, ee;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic r, input logic we, input int a, input int d,
                                input int len, input int it, input logic st, input logic sl,
                                input int es, input int ei, input logic er, input logic ed,
                                input logic ee);
        vec_t v;
        v.rst = r; v.we = we; v.addr = 3'(a); v.data = 4'(d);
        v.len = 3'(len); v.iters = 8'(it); v.start = st; v.stall = sl;
        v.es = 4'(es); v.ei = 3'(ei); v.er = er; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    // Shorthand: idle inputs, expected outputs only
    function automatic vec_t idl(input int es, input int ei, input logic er, input logic ed,
                                 input logic ee);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, es, ei, er, ed, ee);
    endfunction

    task automatic step(input vec_t v);
        exp_t e, g;
        @(negedge clk);
        rst = v.rst; cfg_we = v.we; cfg_addr = v.addr; cfg_data = v.data;
        cfg_len = v.len; cfg_iters = v.iters; start = v.start; stall = v.stall;
        e.es = v.es; e.ei = v.ei; e.er = v.er; e.ed = v.ed; e.ee = v.ee;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        n_vec++;
        if (s !== g.es) begin
            n_bad++; $display("FAIL v%0d s: got %0d exp %0d", n_vec, s, g.es);
        end
        if (ctx_idx !== g.ei) begin
            n_bad++; $display("FAIL v%0d ctx_idx: got %0d exp %0d", n_vec, ctx_idx, g.ei);
        end
        if (running !== g.er) begin
            n_bad++; $display("FAIL v%0d running: got %0b exp %0b", n_vec, running, g.er);
        end
        if (done !== g.ed) begin
            n_bad++; $display("FAIL v%0d done: got %0b exp %0b", n_vec, done, g.ed);
        end
        if (cfg_err !== g.ee) begin
            n_bad++; $display("FAIL v%0d cfg_err: got %0b exp %0b", n_vec, cfg_err, g.ee);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
        cfg_len = 0; cfg_iters = 0; start = 0; stall = 0;

        // Reset for two cycles
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Full-depth run over the freshly reset table: every entry must read 0
        vecs.push_back(mk(0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 1, 0, 0));
        for (int k = 1; k <= 7; k++) vecs.push_back(idl(0, k, 1, 0, 0));
        vecs.push_back(idl(0, 0, 0, 1, 0));
        // Load {3,7,15,1}, len=3 iters=0
        vecs.push_back(mk(0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 1, 0, 3, 0, 1, 0, 0));
        vecs.push_back(idl(7, 1, 1, 0, 0));
        vecs.push_back(idl(15, 2, 1, 0, 0));
        vecs.push_back(idl(1, 3, 1, 0, 0));
        vecs.push_back(idl(0, 0, 0, 1, 0));
        vecs.push_back(idl(0, 0, 0, 0, 0));
        // table[0..1]={5,9}; the second write coincides with start. len=1, iters=2
        vecs.push_back(mk(0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 9, 1, 2, 1, 0, 5, 0, 1, 0, 0));
        vecs.push_back(idl(9, 1, 1, 0, 0));
        vecs.push_back(idl(5, 0, 1, 0, 0));
        vecs.push_back(idl(9, 1, 1, 0, 0));
        vecs.push_back(idl(5, 0, 1, 0, 0));
        vecs.push_back(idl(9, 1, 1, 0, 0));
        vecs.push_back(idl(0, 0, 0, 1, 0));
        // Restore {3,7}; three stalls while s=7, then a stall at the terminal entry
        vecs.push_back(mk(0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 1, 0, 3, 0, 1, 0, 0));
        vecs.push_back(idl(7, 1, 1, 0, 0));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 1, 0, 0));
        vecs.push_back(idl(15, 2, 1, 0, 0));
        vecs.push_back(idl(1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 1, 0, 0));
        vecs.push_back(idl(0, 0, 0, 1, 0));
        // Write during RUN -> cfg_err, no table write; start during RUN ignored
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 1, 0, 3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 12, 0, 0, 0, 0, 7, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 15, 2, 1, 0, 0));
        vecs.push_back(idl(1, 3, 1, 0, 0));
        vecs.push_back(idl(0, 0, 0, 1, 0));
        // len=0: single entry; table[0] must still be 3
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 1, 0, 0));
        vecs.push_back(idl(0, 0, 0, 1, 0));
        vecs.push_back(idl(0, 0, 0, 0, 0));

        foreach (vecs[i]) step(vecs[i]);

        // Hand-written: reset mid-RUN at ctx_idx=2 aborts with no done and clears the table
        step(mk(0, 0, 0, 0, 3, 0, 1, 0, 3, 0, 1, 0, 0));
        step(idl(7, 1, 1, 0, 0));
        step(idl(15, 2, 1, 0, 0));
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(idl(0, 0, 0, 0, 0));
        step(idl(0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        step(idl(0, 0, 0, 1, 0));

        // Hand-written: len=0, iters=3 -> four single-entry passes, each showing table[0]=0
        step(mk(0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0));
        step(idl(0, 0, 1, 0, 0));
        step(idl(0, 0, 1, 0, 0));
        step(idl(0, 0, 1, 0, 0));
        step(idl(0, 0, 0, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
